// File: rtl/i2s_stream_apb_if.sv
// APB register-port bundle for the I2S playback/capture buffer.
// Zero-wait-state slave: pready mirrors penable, so there is no backpressure.
interface i2s_stream_apb_if;
    logic [4:0]  paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;

    modport master (output paddr, psel, penable, pwrite, pwdata, input prdata, pready);
    modport slave  (input paddr, psel, penable, pwrite, pwdata, output prdata, pready);
endinterface

// File: rtl/i2s_stream_apb.sv
// APB-programmable playback/capture FIFOs feeding the I2S shift registers, with DMA watermarks and sticky IRQs.
// Push is visible at the head one cycle later; full/empty accesses are dropped and flagged rather than stalled.
module i2s_stream_apb #(
    parameter int DEPTH_LOG2 = 4,
    parameter int NUM_CH     = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    i2s_stream_apb_if.slave apb,
    output logic [31:0]     pb_data,
    output logic [2:0]      pb_ch,
    input  logic            pb_rd,
    output logic            pb_empty,
    input  logic [31:0]     cap_data,
    input  logic            cap_wr,
    output logic            cap_full,
    output logic            pb_dma_req,
    input  logic            pb_dma_ack,
    output logic            cap_dma_req,
    input  logic            cap_dma_ack,
    output logic            irq
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [LW-1:0]         lvl_t;

    localparam logic [4:0] A_DATA    = 5'h00;
    localparam logic [4:0] A_STATUS  = 5'h04;
    localparam logic [4:0] A_CTRL    = 5'h08;
    localparam logic [4:0] A_WMARK   = 5'h0C;
    localparam logic [4:0] A_IRQ_STS = 5'h10;
    localparam logic [4:0] A_IRQ_EN  = 5'h14;

    logic setup_rd, acc_wr, acc_rd;
    assign setup_rd   = apb.psel & ~apb.penable & ~apb.pwrite;
    assign acc_wr     = apb.psel &  apb.penable &  apb.pwrite;
    assign acc_rd     = apb.psel &  apb.penable & ~apb.pwrite;
    assign apb.pready = apb.penable;

    logic       pb_dma_en, cap_dma_en, pb_mute;
    logic [7:0] pb_wm, cap_wm;
    logic [3:0] irq_sts, irq_en;

    logic [31:0] pb_mem  [DEPTH];
    logic [31:0] cap_mem [DEPTH];
    ptr_t        pb_wp, pb_rp, cap_wp, cap_rp;
    lvl_t        pb_level, cap_level;
    logic        pb_full, cap_empty;

    assign pb_empty  = (pb_level == '0);
    assign pb_full   = (pb_level == lvl_t'(DEPTH));
    assign cap_empty = (cap_level == '0);
    assign cap_full  = (cap_level == lvl_t'(DEPTH));

    logic pb_clear, cap_clear, pb_push_req, cap_pop_req;
    logic pb_push, pb_pop, cap_push, cap_pop;
    assign pb_clear    = acc_wr & (apb.paddr == A_CTRL) & apb.pwdata[0];
    assign cap_clear   = acc_wr & (apb.paddr == A_CTRL) & apb.pwdata[2];
    assign pb_push_req = acc_wr & (apb.paddr == A_DATA);
    assign cap_pop_req = acc_rd & (apb.paddr == A_DATA);

    // A clear swallows any same-cycle push or pop, including its error flag.
    assign pb_push  = pb_push_req & ~pb_full  & ~pb_clear;
    assign pb_pop   = pb_rd       & ~pb_empty & ~pb_clear;
    assign cap_push = cap_wr      & ~cap_full & ~cap_clear;
    assign cap_pop  = cap_pop_req & ~cap_empty & ~cap_clear;

    logic [3:0] irq_evt, irq_w1c;
    assign irq_evt = {cap_pop_req & cap_empty & ~cap_clear,
                      cap_wr      & cap_full  & ~cap_clear,
                      pb_push_req & pb_full   & ~pb_clear,
                      pb_rd       & pb_empty  & ~pb_clear};
    assign irq_w1c = (acc_wr && apb.paddr == A_IRQ_STS) ? apb.pwdata[3:0] : 4'h0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pb_wp    <= '0;
            pb_rp    <= '0;
            pb_level <= '0;
            pb_ch    <= '0;
        end else if (pb_clear) begin
            pb_wp    <= '0;
            pb_rp    <= '0;
            pb_level <= '0;
            pb_ch    <= '0;
        end else begin
            if (pb_push) pb_wp <= pb_wp + 1'b1;
            if (pb_pop)  pb_rp <= pb_rp + 1'b1;
            pb_level <= pb_level + lvl_t'(pb_push) - lvl_t'(pb_pop);
            // Slot advances even on an underflowing pop to keep frames aligned.
            if (pb_rd) pb_ch <= (pb_ch == 3'(NUM_CH - 1)) ? 3'd0 : pb_ch + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_wp    <= '0;
            cap_rp    <= '0;
            cap_level <= '0;
        end else if (cap_clear) begin
            cap_wp    <= '0;
            cap_rp    <= '0;
            cap_level <= '0;
        end else begin
            if (cap_push) cap_wp <= cap_wp + 1'b1;
            if (cap_pop)  cap_rp <= cap_rp + 1'b1;
            cap_level <= cap_level + lvl_t'(cap_push) - lvl_t'(cap_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (pb_push)  pb_mem[pb_wp]   <= apb.pwdata;
        if (cap_push) cap_mem[cap_wp] <= cap_data;
    end

    assign pb_data = (pb_empty | pb_mute) ? 32'h0 : pb_mem[pb_rp];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pb_dma_en  <= 1'b0;
            cap_dma_en <= 1'b0;
            pb_mute    <= 1'b0;
            pb_wm      <= 8'(DEPTH / 2);
            cap_wm     <= 8'(DEPTH / 2);
            irq_en     <= 4'h0;
        end else if (acc_wr) begin
            case (apb.paddr)
                A_CTRL: begin
                    pb_dma_en  <= apb.pwdata[1];
                    cap_dma_en <= apb.pwdata[3];
                    pb_mute    <= apb.pwdata[4];
                end
                A_WMARK: begin
                    pb_wm  <= apb.pwdata[7:0];
                    cap_wm <= apb.pwdata[23:16];
                end
                A_IRQ_EN: irq_en <= apb.pwdata[3:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_sts     <= 4'h0;
            irq         <= 1'b0;
            pb_dma_req  <= 1'b0;
            cap_dma_req <= 1'b0;
        end else begin
            irq_sts     <= (irq_sts & ~irq_w1c) | irq_evt;
            irq         <= |(irq_sts & irq_en);
            pb_dma_req  <= ~pb_dma_ack & pb_dma_en & (8'(pb_level) <= pb_wm) & ~pb_full;
            cap_dma_req <= ~cap_dma_ack & cap_dma_en & (8'(cap_level) >= cap_wm) & ~cap_empty;
        end
    end

    logic [31:0] rd_val;
    always_comb begin
        rd_val = 32'h0;
        case (apb.paddr)
            A_DATA:    rd_val = cap_empty ? 32'h0 : cap_mem[cap_rp];
            A_STATUS:  rd_val = {8'(cap_level), 4'h0, cap_dma_req, cap_dma_en, cap_full, cap_empty,
                                 8'(pb_level),  4'h0, pb_dma_req,  pb_dma_en,  pb_full,  pb_empty};
            A_CTRL:    rd_val = {27'h0, pb_mute, cap_dma_en, 1'b0, pb_dma_en, 1'b0};
            A_WMARK:   rd_val = {8'h0, cap_wm, 8'h0, pb_wm};
            A_IRQ_STS: rd_val = {28'h0, irq_sts};
            A_IRQ_EN:  rd_val = {28'h0, irq_en};
            default:   rd_val = 32'h0;
        endcase
    end

    // Read data is captured in setup so a DATA read samples the head before the access-phase pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      apb.prdata <= 32'h0;
        else if (setup_rd) apb.prdata <= rd_val;
    end
endmodule

// File: tb/tb_i2s_stream_apb.sv
// Directed test-plan scenarios plus randomized traffic, checked every cycle against a queue-based model.
module tb_i2s_stream_apb;
    localparam int DEPTH_LOG2 = 4;
    localparam int NUM_CH     = 2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    localparam logic [4:0] A_DATA    = 5'h00;
    localparam logic [4:0] A_STATUS  = 5'h04;
    localparam logic [4:0] A_CTRL    = 5'h08;
    localparam logic [4:0] A_WMARK   = 5'h0C;
    localparam logic [4:0] A_IRQ_STS = 5'h10;
    localparam logic [4:0] A_IRQ_EN  = 5'h14;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    i2s_stream_apb_if bus ();
    logic [31:0] pb_data;
    logic [2:0]  pb_ch;
    logic        pb_rd, pb_empty, cap_wr, cap_full;
    logic [31:0] cap_data;
    logic        pb_dma_req, pb_dma_ack, cap_dma_req, cap_dma_ack, irq;

    i2s_stream_apb #(.DEPTH_LOG2(DEPTH_LOG2), .NUM_CH(NUM_CH)) dut (
        .clk(clk), .reset_n(reset_n), .apb(bus),
        .pb_data(pb_data), .pb_ch(pb_ch), .pb_rd(pb_rd), .pb_empty(pb_empty),
        .cap_data(cap_data), .cap_wr(cap_wr), .cap_full(cap_full),
        .pb_dma_req(pb_dma_req), .pb_dma_ack(pb_dma_ack),
        .cap_dma_req(cap_dma_req), .cap_dma_ack(cap_dma_ack), .irq(irq)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Reference model state
    logic [31:0] pb_q[$];
    logic [31:0] cap_q[$];
    int          m_ch = 0;
    logic [3:0]  m_sts = 4'h0, m_ien = 4'h0;
    logic        m_pb_en = 1'b0, m_cap_en = 1'b0, m_mute = 1'b0;
    logic        m_pb_req = 1'b0, m_cap_req = 1'b0, m_irq = 1'b0;
    int          m_pb_wm = DEPTH / 2, m_cap_wm = DEPTH / 2;
    logic [31:0] m_prdata = 32'h0;

    function automatic logic [31:0] reg_value(input logic [4:0] a);
        int pl, cl;
        pl = pb_q.size();
        cl = cap_q.size();
        case (a)
            A_DATA:    return (cl > 0) ? cap_q[0] : 32'h0;
            A_STATUS:  return 32'(pl == 0) | (32'(pl == DEPTH) << 1) | (32'(m_pb_en) << 2) | (32'(m_pb_req) << 3)
                            | (32'(pl) << 8) | (32'(cl == 0) << 16) | (32'(cl == DEPTH) << 17)
                            | (32'(m_cap_en) << 18) | (32'(m_cap_req) << 19) | (32'(cl) << 24);
            A_CTRL:    return (32'(m_mute) << 4) | (32'(m_cap_en) << 3) | (32'(m_pb_en) << 1);
            A_WMARK:   return (32'(m_cap_wm) << 16) | 32'(m_pb_wm);
            A_IRQ_STS: return 32'(m_sts);
            A_IRQ_EN:  return 32'(m_ien);
            default:   return 32'h0;
        endcase
    endfunction

    // One clock: snapshot inputs, advance the model at the edge, compare just after it.
    task automatic tick();
        logic s_psel, s_pen, s_pwr, s_pb_rd, s_cap_wr, s_pb_ack, s_cap_ack;
        logic [4:0]  s_a;
        logic [31:0] s_wd, s_cd;
        logic wr, rd_acc, setup_rd, pb_clr, cap_clr, nxt_pb_req, nxt_cap_req, nxt_irq;
        logic [3:0] ev;
        int n;
        s_psel = bus.psel; s_pen = bus.penable; s_pwr = bus.pwrite;
        s_a = bus.paddr; s_wd = bus.pwdata;
        s_pb_rd = pb_rd; s_cap_wr = cap_wr; s_cd = cap_data;
        s_pb_ack = pb_dma_ack; s_cap_ack = cap_dma_ack;
        @(posedge clk);
        wr       = s_psel && s_pen && s_pwr;
        rd_acc   = s_psel && s_pen && !s_pwr;
        setup_rd = s_psel && !s_pen && !s_pwr;
        pb_clr   = wr && s_a == A_CTRL && s_wd[0];
        cap_clr  = wr && s_a == A_CTRL && s_wd[2];
        ev = 4'h0;
        if (setup_rd) m_prdata = reg_value(s_a);
        nxt_pb_req  = !s_pb_ack && m_pb_en && pb_q.size() <= m_pb_wm && pb_q.size() < DEPTH;
        nxt_cap_req = !s_cap_ack && m_cap_en && cap_q.size() >= m_cap_wm && cap_q.size() > 0;
        nxt_irq     = |(m_sts & m_ien);
        if (pb_clr) begin
            pb_q.delete();
            m_ch = 0;
        end else begin
            n = pb_q.size();
            if (s_pb_rd) begin
                if (n > 0) void'(pb_q.pop_front());
                else ev[0] = 1'b1;
                m_ch = (m_ch + 1) % NUM_CH;
            end
            if (wr && s_a == A_DATA) begin
                if (n == DEPTH) ev[1] = 1'b1;
                else pb_q.push_back(s_wd);
            end
        end
        if (cap_clr) begin
            cap_q.delete();
        end else begin
            n = cap_q.size();
            if (rd_acc && s_a == A_DATA) begin
                if (n > 0) void'(cap_q.pop_front());
                else ev[3] = 1'b1;
            end
            if (s_cap_wr) begin
                if (n == DEPTH) ev[2] = 1'b1;
                else cap_q.push_back(s_cd);
            end
        end
        m_sts = (m_sts & ~((wr && s_a == A_IRQ_STS) ? s_wd[3:0] : 4'h0)) | ev;
        if (wr && s_a == A_CTRL) begin
            m_pb_en = s_wd[1]; m_cap_en = s_wd[3]; m_mute = s_wd[4];
        end
        if (wr && s_a == A_WMARK) begin
            m_pb_wm = int'(s_wd[7:0]); m_cap_wm = int'(s_wd[23:16]);
        end
        if (wr && s_a == A_IRQ_EN) m_ien = s_wd[3:0];
        m_pb_req = nxt_pb_req; m_cap_req = nxt_cap_req; m_irq = nxt_irq;
        #1;
        check("pb_data", pb_data, (pb_q.size() == 0 || m_mute) ? 32'h0 : pb_q[0]);
        check("pb_ch", 32'(pb_ch), 32'(m_ch));
        check("pb_empty", 32'(pb_empty), 32'(pb_q.size() == 0));
        check("cap_full", 32'(cap_full), 32'(cap_q.size() == DEPTH));
        check("pb_dma_req", 32'(pb_dma_req), 32'(m_pb_req));
        check("cap_dma_req", 32'(cap_dma_req), 32'(m_cap_req));
        check("irq", 32'(irq), 32'(m_irq));
        check("prdata", bus.prdata, m_prdata);
        check("pready", 32'(bus.pready), 32'(bus.penable));
    endtask

    task automatic apb_idle();
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    endtask

    task automatic apb_write(input logic [4:0] a, input logic [31:0] wd);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = a; bus.pwdata = wd;
        tick();
        bus.penable = 1'b1;
        tick();
        apb_idle();
    endtask

    task automatic apb_read(input logic [4:0] a, output logic [31:0] rd);
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = a;
        tick();
        bus.penable = 1'b1;
        tick();
        rd = bus.prdata;
        apb_idle();
    endtask

    initial begin
        logic [31:0] d, wd;
        logic [4:0]  wa;
        bit          fill;
        apb_idle();
        bus.paddr = 5'h0; bus.pwdata = 32'h0;
        pb_rd = 1'b0; cap_wr = 1'b0; cap_data = 32'h0; pb_dma_ack = 1'b0; cap_dma_ack = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pb_data", pb_data, 32'h0);
        check("rst_pb_ch", 32'(pb_ch), 32'h0);
        check("rst_pb_empty", 32'(pb_empty), 32'h1);
        check("rst_cap_full", 32'(cap_full), 32'h0);
        check("rst_pb_req", 32'(pb_dma_req), 32'h0);
        check("rst_cap_req", 32'(cap_dma_req), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_prdata", bus.prdata, 32'h0);
        reset_n = 1'b1;
        apb_read(A_WMARK, d);  check("rst_wmark", d, 32'h0008_0008);
        apb_read(A_CTRL, d);   check("rst_ctrl", d, 32'h0);
        apb_read(A_STATUS, d); check("rst_status", d, 32'h0001_0001);

        // Basic playback order, slot tagging and underflow
        apb_write(A_DATA, 32'hA); apb_write(A_DATA, 32'hB); apb_write(A_DATA, 32'hC);
        check("s1_head_a", pb_data, 32'hA); check("s1_ch0", 32'(pb_ch), 32'h0);
        apb_read(A_STATUS, d); check("s1_lvl3", (d >> 8) & 32'hFF, 32'h3);
        pb_rd = 1'b1; tick(); pb_rd = 1'b0;
        check("s1_head_b", pb_data, 32'hB); check("s1_ch1", 32'(pb_ch), 32'h1);
        pb_rd = 1'b1; tick(); pb_rd = 1'b0;
        check("s1_head_c", pb_data, 32'hC); check("s1_ch0b", 32'(pb_ch), 32'h0);
        pb_rd = 1'b1; tick(); pb_rd = 1'b0;
        apb_read(A_STATUS, d); check("s1_lvl0", (d >> 8) & 32'hFF, 32'h0);
        pb_rd = 1'b1; tick(); pb_rd = 1'b0;
        check("s1_uf_data", pb_data, 32'h0);
        apb_read(A_IRQ_STS, d); check("s1_uf_flag", d, 32'h1);
        apb_write(A_IRQ_STS, 32'hF);

        // Overflow, interrupt latency and W1C
        apb_write(A_IRQ_EN, 32'h2);
        for (int i = 0; i < DEPTH + 1; i++) apb_write(A_DATA, 32'h200 + i);
        check("s2_irq_lag", 32'(irq), 32'h0);
        tick();
        check("s2_irq_up", 32'(irq), 32'h1);
        apb_read(A_STATUS, d);
        check("s2_full", d & 32'h2, 32'h2); check("s2_lvl16", (d >> 8) & 32'hFF, 32'h10);
        apb_write(A_IRQ_STS, 32'h2);
        tick();
        check("s2_irq_down", 32'(irq), 32'h0);
        apb_read(A_IRQ_STS, d); check("s2_sts_clr", d, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            check("s2_drain", pb_data, 32'h200 + i);
            pb_rd = 1'b1; tick(); pb_rd = 1'b0;
        end
        check("s2_drained", 32'(pb_empty), 32'h1);

        // Playback DMA watermark and ack
        apb_write(A_WMARK, 32'h0008_0004);
        apb_write(A_CTRL, 32'h2);
        for (int i = 0; i < 10; i++) apb_write(A_DATA, 32'h300 + i);
        pb_rd = 1'b1; repeat (6) tick(); pb_rd = 1'b0;
        check("s3_req_lvl5", 32'(pb_dma_req), 32'h0);
        tick(); check("s3_req_lvl4", 32'(pb_dma_req), 32'h1);
        pb_dma_ack = 1'b1; tick(); pb_dma_ack = 1'b0;
        check("s3_ack_low", 32'(pb_dma_req), 32'h0);
        tick(); check("s3_req_back", 32'(pb_dma_req), 32'h1);
        tick(); check("s3_req_hold", 32'(pb_dma_req), 32'h1);
        apb_write(A_CTRL, 32'h0);
        tick(); check("s3_req_dis", 32'(pb_dma_req), 32'h0);

        // Capture DMA and APB reads
        apb_write(A_WMARK, 32'h0002_0004);
        apb_write(A_CTRL, 32'h8);
        cap_wr = 1'b1; cap_data = 32'h11; tick(); cap_data = 32'h22; tick(); cap_wr = 1'b0;
        tick(); check("s4_cap_req", 32'(cap_dma_req), 32'h1);
        apb_read(A_DATA, d); check("s4_rd0", d, 32'h11);
        apb_read(A_DATA, d); check("s4_rd1", d, 32'h22);
        apb_read(A_STATUS, d); check("s4_cap_lvl0", d >> 24, 32'h0);
        apb_read(A_DATA, d); check("s4_rd_empty", d, 32'h0);
        apb_read(A_IRQ_STS, d); check("s4_cap_uf", d & 32'h8, 32'h8);

        // Clear racing a pop
        apb_write(A_CTRL, 32'h1);
        for (int i = 0; i < 5; i++) apb_write(A_DATA, 32'h400 + i);
        pb_rd = 1'b1; tick(); pb_rd = 1'b0;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = A_CTRL; bus.pwdata = 32'h1;
        tick();
        bus.penable = 1'b1; pb_rd = 1'b1; cap_wr = 1'b1; cap_data = 32'h55;
        tick();
        apb_idle(); pb_rd = 1'b0; cap_wr = 1'b0;
        check("s5_empty", 32'(pb_empty), 32'h1);
        check("s5_ch0", 32'(pb_ch), 32'h0);
        apb_read(A_STATUS, d); check("s5_lvl0", (d >> 8) & 32'hFF, 32'h0);
        apb_read(A_CTRL, d); check("s5_ctrl", d, 32'h0);
        apb_read(A_IRQ_STS, d); check("s5_sticky", d, 32'h8);

        // Mute still pops and advances slots
        apb_write(A_CTRL, 32'h10);
        apb_write(A_DATA, 32'h501); apb_write(A_DATA, 32'h502);
        check("s6_mute0", pb_data, 32'h0); check("s6_ch0", 32'(pb_ch), 32'h0);
        apb_read(A_STATUS, d); check("s6_lvl2", (d >> 8) & 32'hFF, 32'h2);
        pb_rd = 1'b1; tick(); pb_rd = 1'b0;
        check("s6_mute1", pb_data, 32'h0); check("s6_ch1", 32'(pb_ch), 32'h1);
        pb_rd = 1'b1; tick(); pb_rd = 1'b0;
        check("s6_ch0b", 32'(pb_ch), 32'h0); check("s6_empty", 32'(pb_empty), 32'h1);
        apb_write(A_CTRL, 32'h0);

        // Randomized traffic alternating fill-heavy and drain-heavy stretches
        for (int i = 0; i < 1200; i++) begin
            fill = ((i / 150) % 2) == 0;
            pb_rd  = fill ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            cap_wr = fill ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0);
            cap_data = $urandom;
            pb_dma_ack  = ($urandom_range(0, 5) == 0);
            cap_dma_ack = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 9))
                0, 1, 2: tick();
                3, 4: if (fill) apb_write(A_DATA, $urandom); else apb_read(A_DATA, d);
                5: apb_write(A_DATA, $urandom);
                6: apb_read(A_DATA, d);
                7: apb_read(5'($urandom_range(0, 7) * 4), d);
                8: begin
                    case ($urandom_range(0, 4))
                        0: begin
                            wa = A_CTRL;
                            wd = {27'h0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                                  $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0};
                        end
                        1: begin
                            wa = A_WMARK;
                            wd = (32'($urandom_range(0, DEPTH + 1)) << 16) | 32'($urandom_range(0, DEPTH + 1));
                        end
                        2: begin wa = A_IRQ_EN;  wd = $urandom; end
                        3: begin wa = A_IRQ_STS; wd = $urandom; end
                        default: begin wa = 5'h18; wd = $urandom; end
                    endcase
                    apb_write(wa, wd);
                end
                default: tick();
            endcase
        end
        pb_rd = 1'b0; cap_wr = 1'b0; pb_dma_ack = 1'b0; cap_dma_ack = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
